ysyx_23060077_ifu_prefetch: RTL

Parametrised instruction-fetch front end with a prefetch queue. It sits between the branch/redirect logic and the IDU, issues sequential fetch requests to the Icache, and buffers up to `DEPTH` fetched (pc, inst) pairs. It presents them to the IDU over a valid/ready handshake. Redirects flush the queue, and any in-flight Icache response is squashed.

---
 rtl/ysyx_23060077_ifu_prefetch_pkg.sv | 22 ++
 rtl/ysyx_23060077_ifu_fifo.sv | 53 +++++
 rtl/ysyx_23060077_ifu_prefetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/ysyx_23060077_ifu_prefetch_pkg.sv
// Shared definitions for the IFU prefetch front end: FENCE opcode, fetch FSM
// encodings and the build-dependent reset PC.
`ifndef YSYX_23060077_RESET_PC
`ifdef NPC_SIM
`define YSYX_23060077_RESET_PC 32'h8000_0000
`else
`define YSYX_23060077_RESET_PC 32'h3000_0000
`endif
`endif

package ysyx_23060077_ifu_prefetch_pkg;

  localparam logic [6:0]  FENCE        = 7'b0001111;
  localparam logic [31:0] IFP_RESET_PC = `YSYX_23060077_RESET_PC;

  typedef enum logic [1:0] {
    IFP_IDLE = 2'd0,
    IFP_REQ  = 2'd1,
    IFP_DROP = 2'd2
  } ifp_state_t;

endpackage

// File: rtl/ysyx_23060077_ifu_fifo.sv
// Circular-buffer synchronous FIFO with push, pop, flush and occupancy count.
// Full/empty come from the count; flush wins over a same-cycle push or pop.
module ysyx_23060077_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full queue is only accepted when the head leaves the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != DEPTH_C) || w_pop);

  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_valid     = (r_count != '0);
  assign o_count     = r_count;

endmodule

// File: rtl/ysyx_23060077_ifu_prefetch.sv
// Instruction-fetch front end: one outstanding Icache request at a time, a
// DEPTH-entry prefetch queue toward the IDU, and redirect-driven flush/squash.
module ysyx_23060077_ifu_prefetch
  import ysyx_23060077_ifu_prefetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFP_RESET_PC),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              fetch_en_i,
  output logic              ic_req_valid_o,
  output logic [ADDR_W-1:0] ic_req_addr_o,
  input  logic              ic_resp_valid_i,
  input  logic [INST_W-1:0] ic_resp_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic              fence_i_o,
  output logic [CW-1:0]     count_o,
  output ifp_state_t        dbg_state_o
);

  // Handshake: the IDU takes the head on a cycle where out_valid_o && out_ready_i
  // and no redirect is present; a redirect in that cycle voids the transfer.

  localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

  ifp_state_t                r_state;
  ifp_state_t                w_state_next;
  logic [ADDR_W-1:0]         r_fetch_pc;
  logic [ADDR_W+INST_W-1:0]  w_head;
  logic [INST_W-1:0]         w_head_inst;
  logic                      w_push;
  logic                      w_pop;
  logic [CW:0]               w_count_post;
  logic                      w_room_now;
  logic                      w_room_post;

  assign w_pop  = out_valid_o && out_ready_i && !redirect_valid_i;
  assign w_push = (r_state == IFP_REQ) && ic_resp_valid_i && !redirect_valid_i;

  // In IDLE nothing is in flight, so count < DEPTH reserves the response slot.
  assign w_count_post = {1'b0, count_o} + (CW + 1)'(w_push) - (CW + 1)'(w_pop);
  assign w_room_now   = {1'b0, count_o} < DEPTH_X;
  assign w_room_post  = w_count_post < DEPTH_X;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IFP_IDLE: begin
        if (!redirect_valid_i && fetch_en_i && w_room_now) w_state_next = IFP_REQ;
      end
      IFP_REQ: begin
        if (redirect_valid_i) begin
          w_state_next = ic_resp_valid_i ? IFP_IDLE : IFP_DROP;
        end else if (ic_resp_valid_i) begin
          w_state_next = (fetch_en_i && w_room_post) ? IFP_REQ : IFP_IDLE;
        end
      end
      IFP_DROP: begin
        if (ic_resp_valid_i) w_state_next = IFP_IDLE;
      end
      default: w_state_next = IFP_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IFP_IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid_i)  r_fetch_pc <= redirect_pc_i;
      else if (w_push)       r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
    end
  end

  ysyx_23060077_ifu_fifo #(
    .WIDTH(ADDR_W + INST_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_flush     (redirect_valid_i),
    .i_push      (w_push),
    .i_push_data ({r_fetch_pc, ic_resp_data_i}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_valid     (out_valid_o),
    .o_count     (count_o)
  );

  // DROP keeps the request raised: the Icache still owes a response.
  assign ic_req_valid_o = (r_state != IFP_IDLE);
  assign ic_req_addr_o  = r_fetch_pc;
  assign dbg_state_o    = r_state;

  assign w_head_inst = w_head[INST_W-1:0];
  assign out_pc_o    = out_valid_o ? w_head[ADDR_W+INST_W-1:INST_W] : '0;
  assign out_inst_o  = out_valid_o ? w_head_inst : '0;
  assign fence_i_o   = out_valid_o && (w_head_inst[6:0] == FENCE) && w_head_inst[12];

endmodule
